// File: rtl/mac_pkg.sv
// Shared MAC definitions: receive FSM states, framing bytes and CRC-32 constants.
// Imported by the receive framer and by the CRC byte engine.
package mac_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      DATA,
      DONE,
      DROP
   } rx_state_e;

   localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
   localparam logic [7:0]  SFD_BYTE        = 8'hD5;

   localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
   // Bit-reversed form of CRC32_POLY for the LSB-first shift.
   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

endpackage

// File: rtl/mac_rx_framer_if.sv
// GMII receive byte stream in, framed bytes and per-frame status out.
// slave is the framer side, master is the PHY/consumer side.
interface mac_rx_framer_if #(
   parameter int CNT_WIDTH = 16
);

   logic [7:0]           gmii_rxd;
   logic                 gmii_rx_dv;
   logic                 gmii_rx_er;
   logic [7:0]           rx_data;
   logic                 rx_data_valid;
   logic                 rx_sof;
   logic                 rx_frame_done;
   logic                 rx_frame_good;
   logic                 rx_err_crc;
   logic                 rx_err_len;
   logic                 rx_err_phy;
   logic [CNT_WIDTH-1:0] frame_length;

   modport master (
      output gmii_rxd, gmii_rx_dv, gmii_rx_er,
      input  rx_data, rx_data_valid, rx_sof, rx_frame_done,
      input  rx_frame_good, rx_err_crc, rx_err_len, rx_err_phy,
      input  frame_length
   );

   modport slave (
      input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
      output rx_data, rx_data_valid, rx_sof, rx_frame_done,
      output rx_frame_good, rx_err_crc, rx_err_len, rx_err_phy,
      output frame_length
   );

endinterface

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update for one byte, LSB first.
// Shared by the receive framer and the transmit side.
module crc32_d8
   import mac_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   logic [31:0] c;

   always_comb begin
      c = crc_in ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/mac_rx_framer.sv
// Receive framer: strips preamble/SFD, withholds the 4-byte FCS through a
// delay line, checks CRC-32 and length, and strobes status once per frame.
module mac_rx_framer
   import mac_pkg::*;
#(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518,
   parameter int CNT_WIDTH = 16
) (
   input  logic           rx_clk,
   input  logic           reset,
   mac_rx_framer_if.slave bus
);

   rx_state_e            state_q, state_d;
   logic [3:0][7:0]      dly_q, dly_d;
   logic [31:0]          crc_q, crc_d, crc_nxt;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] flen_q, flen_d;
   logic                 phy_q, phy_d;
   logic [7:0]           rx_data_q, rx_data_d;
   logic                 valid_q, valid_d;
   logic                 sof_q, sof_d;
   logic                 done_q, done_d;
   logic                 good_q, good_d;
   logic                 ecrc_q, ecrc_d;
   logic                 elen_q, elen_d;
   logic                 ephy_q, ephy_d;

   crc32_d8 u_crc (
      .crc_in  (crc_q),
      .data    (bus.gmii_rxd),
      .crc_out (crc_nxt)
   );

   always_comb begin
      state_d   = state_q;
      dly_d     = dly_q;
      crc_d     = crc_q;
      cnt_d     = cnt_q;
      phy_d     = phy_q;
      flen_d    = flen_q;
      rx_data_d = rx_data_q;
      valid_d   = 1'b0;
      sof_d     = 1'b0;
      done_d    = 1'b0;
      good_d    = good_q;
      ecrc_d    = ecrc_q;
      elen_d    = elen_q;
      ephy_d    = ephy_q;
      // Frame context only lives in DATA; every other state holds it cleared.
      if (state_q != DATA) begin
         dly_d = '0;
         crc_d = CRC32_INIT;
         cnt_d = '0;
         phy_d = 1'b0;
      end
      unique case (state_q)
         IDLE, PREAMBLE: begin
            if (!bus.gmii_rx_dv) begin
               state_d = IDLE;
            end else begin
               unique case (1'b1)
                  bus.gmii_rxd == PREAMBLE_BYTE: state_d = PREAMBLE;
                  bus.gmii_rxd == SFD_BYTE:      state_d = DATA;
                  default:                       state_d = DROP;
               endcase
            end
         end
         DATA: begin
            if (bus.gmii_rx_dv) begin
               dly_d = {dly_q[2:0], bus.gmii_rxd};
               crc_d = crc_nxt;
               phy_d = phy_q | bus.gmii_rx_er;
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               if (cnt_q >= CNT_WIDTH'(4)) begin
                  rx_data_d = dly_q[3];
                  valid_d   = 1'b1;
                  sof_d     = (cnt_q == CNT_WIDTH'(4));
               end
            end else begin
               state_d = DONE;
               done_d  = 1'b1;
               flen_d  = cnt_q;
               ecrc_d  = (crc_q != CRC32_RESIDUE);
               elen_d  = (cnt_q < CNT_WIDTH'(MIN_FRAME)) ||
                         (cnt_q > CNT_WIDTH'(MAX_FRAME));
               ephy_d  = phy_q | bus.gmii_rx_er;
               good_d  = !(ecrc_d || elen_d || ephy_d);
            end
         end
         DONE: state_d = IDLE;
         DROP: begin
            if (!bus.gmii_rx_dv) state_d = IDLE;
         end
         default: state_d = DROP;
      endcase
   end

   always_ff @(posedge rx_clk) begin
      if (!reset) begin
         state_q   <= DROP;
         dly_q     <= '0;
         crc_q     <= CRC32_INIT;
         cnt_q     <= '0;
         phy_q     <= 1'b0;
         flen_q    <= '0;
         rx_data_q <= '0;
         valid_q   <= 1'b0;
         sof_q     <= 1'b0;
         done_q    <= 1'b0;
         good_q    <= 1'b0;
         ecrc_q    <= 1'b0;
         elen_q    <= 1'b0;
         ephy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dly_q     <= dly_d;
         crc_q     <= crc_d;
         cnt_q     <= cnt_d;
         phy_q     <= phy_d;
         flen_q    <= flen_d;
         rx_data_q <= rx_data_d;
         valid_q   <= valid_d;
         sof_q     <= sof_d;
         done_q    <= done_d;
         good_q    <= good_d;
         ecrc_q    <= ecrc_d;
         elen_q    <= elen_d;
         ephy_q    <= ephy_d;
      end
   end

   assign bus.rx_data       = rx_data_q;
   assign bus.rx_data_valid = valid_q;
   assign bus.rx_sof        = sof_q;
   assign bus.rx_frame_done = done_q;
   assign bus.rx_frame_good = good_q;
   assign bus.rx_err_crc    = ecrc_q;
   assign bus.rx_err_len    = elen_q;
   assign bus.rx_err_phy    = ephy_q;
   assign bus.frame_length  = flen_q;

endmodule
